// File: rtl/bf2_bundle_pipe.sv
// rtl/bf2_bundle_pipe.sv - two-stage radix-2 butterfly over a parallel sample bundle
module bf2_bundle_pipe #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int OFFSET = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              mode_tw,
  input  logic                              mode_scale,
  input  logic [DEPTH-1:0][WIDTH-1:0]       din_R,
  input  logic [DEPTH-1:0][WIDTH-1:0]       din_Q,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DEPTH-1:0][WIDTH:0]         dout_R,
  output logic [DEPTH-1:0][WIDTH:0]         dout_Q,
  output logic [15:0]                       frame_cnt
);

  localparam int W1 = WIDTH + 1;
  localparam int W2 = WIDTH + 2;

  // Samples are two's complement; arithmetic is done on sign-extended copies.
  logic                          s1_valid;
  logic                          s1_tw;
  logic                          s1_sc;
  logic [DEPTH-1:0][WIDTH-1:0]   s1_r;
  logic [DEPTH-1:0][WIDTH-1:0]   s1_q;
  logic [DEPTH-1:0][W1-1:0]      res_r;
  logic [DEPTH-1:0][W1-1:0]      res_q;
  logic                          s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // Rounded halving: (x + 1) >>> 1 with one guard bit so +1 cannot wrap.
  function automatic logic [W1-1:0] scale_fn(input logic [W1-1:0] x, input logic en);
    logic signed [W2-1:0] t;
    t = {x[W1-1], x} + W2'(1);
    t = t >>> 1;
    scale_fn = en ? t[W1-1:0] : x;
  endfunction

  for (genvar g = 0; g < DEPTH / (2 * OFFSET); g++) begin : g_grp
    for (genvar j = 0; j < OFFSET; j++) begin : g_pair
      localparam int IA = g * 2 * OFFSET + j;
      localparam int IB = IA + OFFSET;
      // Upper half of each pair group gets the -j rotation on the difference leg.
      localparam bit TW_POS = (j >= OFFSET / 2);

      logic [W1-1:0] ar, br, aq, bq;
      logic [W1-1:0] sum_r, sum_q, dif_r, dif_q, rot_r, rot_q;
      logic          twid;

      assign ar    = {s1_r[IA][WIDTH-1], s1_r[IA]};
      assign br    = {s1_r[IB][WIDTH-1], s1_r[IB]};
      assign aq    = {s1_q[IA][WIDTH-1], s1_q[IA]};
      assign bq    = {s1_q[IB][WIDTH-1], s1_q[IB]};
      assign sum_r = ar + br;
      assign sum_q = aq + bq;
      assign dif_r = ar - br;
      assign dif_q = aq - bq;
      assign twid  = s1_tw && TW_POS;
      assign rot_r = twid ? dif_q : dif_r;
      assign rot_q = twid ? (W1'(0) - dif_r) : dif_q;

      assign res_r[IA] = scale_fn(sum_r, s1_sc);
      assign res_q[IA] = scale_fn(sum_q, s1_sc);
      assign res_r[IB] = scale_fn(rot_r, s1_sc);
      assign res_q[IB] = scale_fn(rot_q, s1_sc);
    end
  end

  // Pipeline registers, handshake bookkeeping and delivered-bundle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_tw     <= 1'b0;
      s1_sc     <= 1'b0;
      s1_r      <= '0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      dout_R    <= '0;
      dout_Q    <= '0;
      frame_cnt <= '0;
    end else begin
      // A handshake in the flush cycle is still a delivered bundle.
      if (out_valid && out_ready) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (flush) begin
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (s2_load) begin
          out_valid <= s1_valid;
          if (s1_valid) begin
            dout_R <= res_r;
            dout_Q <= res_q;
          end
        end
        if (in_ready) begin
          s1_valid <= in_valid;
          if (in_valid) begin
            s1_r  <= din_R;
            s1_q  <= din_Q;
            s1_tw <= mode_tw;
            s1_sc <= mode_scale;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bf2_bundle_pipe.sv
// tb/tb_bf2_bundle_pipe.sv - self-checking bench for bf2_bundle_pipe
module tb_bf2_bundle_pipe;

  localparam int W = 9;
  localparam int D = 16;
  localparam int O = 8;

  typedef logic [D-1:0][W-1:0] bin_t;
  typedef logic [D-1:0][W:0]   bout_t;
  typedef struct { bout_t r; bout_t q; } exp_t;
  typedef struct {
    int ia; int ra; int rb; int qa; int qb; bit tw; bit sc;
    int era; int erb; int eqa; int eqb;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        mode_tw;
  logic        mode_scale;
  bin_t        din_R;
  bin_t        din_Q;
  logic        out_valid;
  logic        out_ready;
  bout_t       dout_R;
  bout_t       dout_Q;
  logic [15:0] frame_cnt;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  bit   prev_stall = 0;
  bit   saw_ir_low = 0;
  bout_t held_r, held_q;

  bf2_bundle_pipe #(.WIDTH(W), .DEPTH(D), .OFFSET(O)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode_tw(mode_tw), .mode_scale(mode_scale),
    .din_R(din_R), .din_Q(din_Q),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout_R(dout_R), .dout_Q(dout_Q), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference butterfly written directly from the arithmetic rules.
  task automatic model(input bin_t r, input bin_t q, input bit tw, input bit sc,
                       output bout_t er, output bout_t eq);
    for (int i = 0; i < O; i++) begin
      int ar, br, aq, bq, sr, sq, dr, dq, t;
      ar = int'($signed(r[i]));   br = int'($signed(r[i+O]));
      aq = int'($signed(q[i]));   bq = int'($signed(q[i+O]));
      sr = ar + br; sq = aq + bq; dr = ar - br; dq = aq - bq;
      if (tw && i >= O/2) begin t = dr; dr = dq; dq = -t; end
      if (sc) begin
        sr = (sr + 1) >>> 1; sq = (sq + 1) >>> 1;
        dr = (dr + 1) >>> 1; dq = (dq + 1) >>> 1;
      end
      er[i] = 10'(sr); er[i+O] = 10'(dr);
      eq[i] = 10'(sq); eq[i+O] = 10'(dq);
    end
  endtask

  // Offer one bundle starting just after a rising edge; returns just after its accepting edge.
  task automatic send(input bin_t r, input bin_t q, input bit tw, input bit sc,
                      input bout_t er, input bout_t eq, input bit push);
    bit ok;
    int n;
    ok = 0; n = 0;
    in_valid = 1; din_R = r; din_Q = q; mode_tw = tw; mode_scale = sc;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk);
      if (ok && push) sb.push_back('{er, eq});
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic send_rand(input bit push);
    bin_t r, q;
    bout_t er, eq;
    bit tw, sc;
    for (int i = 0; i < D; i++) begin
      r[i] = 9'($urandom);
      q[i] = 9'($urandom);
    end
    tw = 1'($urandom); sc = 1'($urandom);
    model(r, q, tw, sc, er, eq);
    send(r, q, tw, sc, er, eq, push);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 320'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor: scoreboard pop on handshake, stability while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 320'(out_valid), 1);
        chk("stall_hold", {dout_R, dout_Q}, {held_r, held_q});
      end
      if (in_valid && !in_ready) saw_ir_low = 1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 0, 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("dout_R", dout_R, e.r);
          chk("dout_Q", dout_Q, e.q);
        end
      end
      prev_stall = out_valid && !out_ready && !flush;
      held_r = dout_R;
      held_q = dout_Q;
    end
  end

  initial begin
    vec_t  tbl[8];
    bin_t  r, q;
    bout_t er, eq;
    int    fc;

    tbl[0] = '{0, 255,  255,    0,    0, 1'b0, 1'b0,  510,   0,    0,   0};
    tbl[1] = '{2, 255, -256,    0,    0, 1'b0, 1'b0,   -1, 511,    0,   0};
    tbl[2] = '{1, -256, -256,   0,    0, 1'b0, 1'b1, -256,   0,    0,   0};
    tbl[3] = '{0, 255,  255,    0,    0, 1'b0, 1'b1,  255,   0,    0,   0};
    tbl[4] = '{4,  10,    5,   20,   10, 1'b1, 1'b0,   15,  10,   30,  -5};
    tbl[5] = '{3,  10,    5,   20,   10, 1'b1, 1'b0,   15,   5,   30,  10};
    tbl[6] = '{5,  -7,    3,    4,    9, 1'b1, 1'b1,   -2,  -2,    7,   5};
    tbl[7] = '{7, -256, 255, -256, -256, 1'b1, 1'b1,    0,   0, -256, 256};

    rst_n = 0; flush = 0; in_valid = 0; mode_tw = 0; mode_scale = 0;
    din_R = '0; din_Q = '0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 320'(out_valid), 0);
    chk("reset_in_ready", 320'(in_ready), 1);
    chk("reset_frame_cnt", 320'(frame_cnt), 0);
    chk("reset_dout", {dout_R, dout_Q}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Directed vectors streamed back-to-back.
    for (int v = 0; v < 8; v++) begin
      r = '0; q = '0; er = '0; eq = '0;
      r[tbl[v].ia]     = 9'(tbl[v].ra);
      r[tbl[v].ia + O] = 9'(tbl[v].rb);
      q[tbl[v].ia]     = 9'(tbl[v].qa);
      q[tbl[v].ia + O] = 9'(tbl[v].qb);
      er[tbl[v].ia]     = 10'(tbl[v].era);
      er[tbl[v].ia + O] = 10'(tbl[v].erb);
      eq[tbl[v].ia]     = 10'(tbl[v].eqa);
      eq[tbl[v].ia + O] = 10'(tbl[v].eqb);
      send(r, q, tbl[v].tw, tbl[v].sc, er, eq, 1);
    end
    drain();
    chk("frame_cnt_table", 320'(frame_cnt), 8);

    // Five bundles with a three-cycle output stall in the middle.
    fc = int'(frame_cnt);
    saw_ir_low = 0;
    fork
      begin
        for (int k = 0; k < 5; k++) send_rand(1);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    chk("stall_in_ready_low", 320'(saw_ir_low), 1);
    chk("frame_cnt_stream", 320'(frame_cnt), 320'(fc + 5));

    // Asynchronous reset with two bundles in flight.
    out_ready = 0;
    send_rand(1);
    send_rand(1);
    rst_n = 0;
    #1;
    chk("arst_out_valid", 320'(out_valid), 0);
    chk("arst_dout", {dout_R, dout_Q}, 0);
    chk("arst_frame_cnt", 320'(frame_cnt), 0);
    chk("arst_in_ready", 320'(in_ready), 1);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1; out_ready = 1;
    send_rand(1);
    @(negedge clk);
    chk("latency_c1", 320'(out_valid), 0);
    @(negedge clk);
    chk("latency_c2", 320'(out_valid), 1);
    drain();
    chk("frame_cnt_after_rst", 320'(frame_cnt), 1);

    // Flush with two bundles in flight and a third offered.
    out_ready = 0;
    send_rand(1);
    send_rand(1);
    fc = int'(frame_cnt);
    flush = 1; in_valid = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    sb.delete();
    chk("flush_in_ready", 320'(in_ready), 1);
    chk("flush_out_valid", 320'(out_valid), 0);
    out_ready = 1;
    repeat (4) @(negedge clk);
    chk("flush_frame_cnt", 320'(frame_cnt), 320'(fc));
    @(posedge clk); #1;

    // Flush coinciding with an output handshake.
    fc = int'(frame_cnt);
    send_rand(1);
    @(posedge clk); #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_hs_frame_cnt", 320'(frame_cnt), 320'(fc + 1));
    chk("flush_hs_out_valid", 320'(out_valid), 0);
    chk("flush_hs_sb_empty", 320'(sb.size()), 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
